// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adder_pkg
// Description : Shared types and defaults for the bit-serial adder path.
//               add_state_t  - sequencer state (IDLE / RUN)
//               DEFAULT_WIDTH - default operand width in bits
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } add_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/fullAdder.sv
`default_nettype none
// ============================================================================
// Module      : fullAdder
// Description : One-bit full adder cell. Purely combinational, holds no state.
// Ports       : A, B   - operand bits
//               cin    - carry in
//               sum    - A ^ B ^ cin
//               cout   - majority(A, B, cin)
// Revision    : 1.0 - initial release
// ============================================================================
module fullAdder (
  input  logic A,
  input  logic B,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = A ^ B ^ cin;
  assign cout = (A & B) | (A & cin) | (B & cin);

endmodule : fullAdder
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_seq
// Description : Bit-serial adder sequencer. Captures two WIDTH-bit operands and
//               a carry-in on an accepted start, then adds them LSB-first, one
//               bit per clock, through a single fullAdder cell. The completed
//               sum and carry-out are presented on held registers together
//               with a one-cycle done pulse.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               start  - begin an addition (accepted only when idle)
//               a, b   - operands, captured on accepted start
//               cin    - carry-in, captured on accepted start
//               busy   - addition in progress (registered)
//               done   - one-cycle completion pulse
//               sum    - result of last completed addition (held)
//               cout   - carry-out of last completed addition (held)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  add_state_t         r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_carry;
  logic [WIDTH-1:0]   r_r_sh;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_fa_sum;
  logic               w_fa_cout;
  logic [WIDTH-1:0]   w_r_next;

  fullAdder u_fa (
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // Result register shifts right with the new bit entering at the MSB, so
  // after WIDTH shifts bit 0 lands in the LSB. A 1-bit result has nothing to
  // shift, so the new bit is the whole result.
  generate
    if (WIDTH == 1) begin : g_r_single
      assign w_r_next = w_fa_sum;
    end else begin : g_r_shift
      assign w_r_next = {w_fa_sum, r_r_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_r_sh  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_fa_cout;
          r_r_sh  <= w_r_next;
          r_cnt   <= r_cnt + 1'b1;
          // Final bit: publish the completed result in the same edge so the
          // outputs never expose a partially shifted value.
          if (r_cnt == c_LAST) begin
            r_sum   <= w_r_next;
            r_cout  <= w_fa_cout;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_add_seq
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_seq
// Description : Self-checking bench for serial_add_seq. Drives an 8-bit and a
//               1-bit instance and compares against plain integer addition.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  // Pulses start for one edge; returns at the falling edge just after it.
  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Counts falling edges until done (bounded); optionally scrambles inputs.
  task automatic wait_done8(input bit scramble, output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      if (scramble) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset8: got busy/done/cout/sum=%b required 0", {busy8, done8, cout8, sum8});
    end
    n_checks++;
    if ({busy1, done1, cout1, sum1} !== 4'd0) begin
      n_errors++;
      $display("FAIL reset1: got busy/done/cout/sum=%b required 0", {busy1, done1, cout1, sum1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      n_errors++;
      $display("FAIL post_reset_idle: got %b required 0", {busy8, done8, cout8, sum8});
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [7:0] tb [3] = '{8'h3C, 8'h01, 8'hFF};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [8:0] te [3] = '{9'h096, 9'h100, 9'h1FF};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      start8_op(ta[i], tb[i], tc[i]);
      n_checks++;
      if (busy8 !== 1'b1) begin
        n_errors++;
        $display("FAIL directed_busy_rise[%0d]: got %b required 1", i, busy8);
      end
      wait_done8(1'b0, lat, bc);
      n_checks++;
      if (lat !== 8 || bc !== 8) begin
        n_errors++;
        $display("FAIL directed_timing[%0d]: got latency %0d busy %0d required 8/8", i, lat, bc);
      end
      n_checks++;
      if ({cout8, sum8} !== te[i] || busy8 !== 1'b0) begin
        n_errors++;
        $display("FAIL directed_result[%0d]: got cout/sum %h busy %b required %h busy 0",
                 i, {cout8, sum8}, busy8, te[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat, bc;
    bit bad;
    start8_op(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(1'b0, lat, bc);
    n_checks++;
    if (lat + 3 !== 8 || {cout8, sum8} !== 9'h030) begin
      n_errors++;
      $display("FAIL ignore_result: got latency %0d cout/sum %h required 8 / 030", lat + 3, {cout8, sum8});
    end
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8 || sum8 !== 8'h30) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL ignore_hold: got done %b busy %b sum %h required 0 0 30", done8, busy8, sum8);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit held_bad;
    start8_op(8'h40, 8'h02, 1'b0);
    wait_done8(1'b0, lat, bc);
    // Request issued in the done cycle itself.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_accept: got busy %b done %b required 1 0", busy8, done8);
    end
    lat = 0; held_bad = 1'b0;
    while (!done8 && lat < 40) begin
      if (sum8 !== 8'h42) held_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (held_bad || lat !== 8) begin
      n_errors++;
      $display("FAIL b2b_hold: got latency %0d held_error %b required 8 0", lat, held_bad);
    end
    n_checks++;
    if ({cout8, sum8} !== 9'h002) begin
      n_errors++;
      $display("FAIL b2b_result: got %h required 002", {cout8, sum8});
    end
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || sum8 !== 8'h02) begin
      n_errors++;
      $display("FAIL done_pulse: got done %b sum %h required 0 02", done8, sum8);
    end
  endtask

  task automatic test_async_reset();
    int lat, bc;
    start8_op(8'h11, 8'h22, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      n_errors++;
      $display("FAIL async_reset: got busy/done/cout/sum=%b required 0", {busy8, done8, cout8, sum8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    start8_op(8'h03, 8'h04, 1'b0);
    wait_done8(1'b0, lat, bc);
    n_checks++;
    if (lat !== 8 || {cout8, sum8} !== 9'h007) begin
      n_errors++;
      $display("FAIL after_reset: got latency %0d cout/sum %h required 8 / 007", lat, {cout8, sum8});
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] exp;
    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = ref_add8(ra, rb, rc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start8_op(ra, rb, rc);
      wait_done8(1'b1, lat, bc);
      n_checks++;
      if ({cout8, sum8} !== exp || lat !== 8) begin
        n_errors++;
        $display("FAIL random[%0d]: %h+%h+%b got %h lat %0d required %h lat 8",
                 i, ra, rb, rc, {cout8, sum8}, lat, exp);
      end
    end
  endtask

  task automatic test_width1();
    logic [2:0] v;
    int exp;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      exp = int'(v[2]) + int'(v[1]) + int'(v[0]);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
      n_checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_errors++;
        $display("FAIL w1_run[%0d]: got busy %b done %b required 1 0", i, busy1, done1);
      end
      @(negedge clk);
      n_checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || {cout1, sum1} !== 2'(exp)) begin
        n_errors++;
        $display("FAIL w1_result[%0d]: got done %b busy %b cout/sum %b required 1 0 %b",
                 i, done1, busy1, {cout1, sum1}, 2'(exp));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule : tb_serial_add_seq
`default_nettype wire
